img_frame_seq: RTL and testbench

Frame sequencer for the padded image buffer. Accepts a start pulse, moves exactly WIDTH×DEPTH pixels from a valid/ready source into the buffer, inserts a turnaround cycle, then streams the frame back out under sink back-pressure. It signals completion or error to the host. Sits between the host/testbench pixel source/sink and the buffer's enable / enable_process / finish pins; pixel data bypasses this block.

---
 rtl/img_frame_seq_if.sv | 54 +++++
 rtl/img_frame_seq.sv | 179 +++++++++++++++++
 tb/tb_img_frame_seq.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/img_frame_seq_if.sv
// img_frame_seq_if: host/buffer-side control bundle of the frame sequencer.
// The master modport is the host side (pixel source/sink, buffer finish flag).
// The slave modport is the sequencer itself.
interface img_frame_seq_if;

    localparam int unsigned PIX_W = 9;

    logic             start;
    logic             src_valid;
    logic             src_ready;
    logic             buf_enable;
    logic             sink_ready;
    logic             buf_enable_process;
    logic             out_valid;
    logic             buf_finish;
    logic [PIX_W-1:0] pix_x;
    logic [PIX_W-1:0] pix_y;
    logic             busy;
    logic             done;
    logic             error;

    modport master (
        output start,
        output src_valid,
        output sink_ready,
        output buf_finish,
        input  src_ready,
        input  buf_enable,
        input  buf_enable_process,
        input  out_valid,
        input  pix_x,
        input  pix_y,
        input  busy,
        input  done,
        input  error
    );

    modport slave (
        input  start,
        input  src_valid,
        input  sink_ready,
        input  buf_finish,
        output src_ready,
        output buf_enable,
        output buf_enable_process,
        output out_valid,
        output pix_x,
        output pix_y,
        output busy,
        output done,
        output error
    );

endinterface

// File: rtl/img_frame_seq.sv
// img_frame_seq: frame sequencer for the padded image buffer.
// Loads WIDTH x DEPTH pixels, one turnaround cycle, streams the frame out,
// then reports done (or error). Pixel data does not pass through here.
// Optional feature macro: IMG_SEQ_TIMEOUT_EN (DRAIN waits for buf_finish,
// bounded by TIMEOUT cycles, otherwise enters ERR).
module img_frame_seq #(
    parameter int unsigned WIDTH   = 410,
    parameter int unsigned DEPTH   = 361,
    parameter int unsigned TIMEOUT = 16
) (
    input logic            clk,
    input logic            rst_n,
    img_frame_seq_if.slave bus
);

    localparam int unsigned PIX_W = 9;
    localparam logic [PIX_W-1:0] X_LAST = PIX_W'(WIDTH - 1);
    localparam logic [PIX_W-1:0] Y_LAST = PIX_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_TURN,
        S_PROC,
        S_DRAIN,
        S_DONE,
        S_ERR
    } state_e;

    state_e           state_q, state_d;
    logic [PIX_W-1:0] pix_x_q, pix_x_d;
    logic [PIX_W-1:0] pix_y_q, pix_y_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             step_c;
    logic             last_c;

`ifdef IMG_SEQ_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             error_q, error_d;
`endif

    // Mealy handshake: load/read strobes follow the live valid/ready inputs
    assign bus.src_ready          = (state_q == S_LOAD);
    assign bus.buf_enable         = (state_q == S_LOAD) & bus.src_valid;
    assign bus.buf_enable_process = (state_q == S_PROC) & bus.sink_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.pix_x     = pix_x_q;
    assign bus.pix_y     = pix_y_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

`ifdef IMG_SEQ_TIMEOUT_EN
    assign bus.error = error_q;
`else
    // Without the timeout, DRAIN is fixed-length and ERR is unreachable
    assign bus.error = 1'b0;
    logic unused_c;
    assign unused_c = ^{bus.buf_finish, 32'(TIMEOUT)};
`endif

    // One pixel moves per load transfer or per process read
    assign step_c = bus.buf_enable | bus.buf_enable_process;
    assign last_c = step_c && (pix_x_q == X_LAST) && (pix_y_q == Y_LAST);

    // Next-state, raster counter walk and registered-output decode
    always_comb begin
        state_d = state_q;
        pix_x_d = pix_x_q;
        pix_y_d = pix_y_q;
`ifdef IMG_SEQ_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif

        // x is the fast index; both wrap to zero after the last pixel
        if (step_c) begin
            if (pix_x_q == X_LAST) begin
                pix_x_d = '0;
                pix_y_d = (pix_y_q == Y_LAST) ? '0 : pix_y_q + PIX_W'(1);
            end else begin
                pix_x_d = pix_x_q + PIX_W'(1);
            end
        end

        unique case (state_q)
            S_IDLE: begin
                pix_x_d = '0;
                pix_y_d = '0;
                if (bus.start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (last_c) begin
                    state_d = S_TURN;
                end
            end
            // Guard cycle so enable and enable_process are never both high
            S_TURN: begin
                state_d = S_PROC;
            end
            S_PROC: begin
                if (last_c) begin
                    state_d = S_DRAIN;
`ifdef IMG_SEQ_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            S_DRAIN: begin
`ifdef IMG_SEQ_TIMEOUT_EN
                if (bus.buf_finish) begin
                    state_d = S_DONE;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`else
                state_d = S_DONE;
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                pix_x_d = '0;
                pix_y_d = '0;
                if (bus.start) begin
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
                pix_x_d = '0;
                pix_y_d = '0;
            end
        endcase

        // Status flags are decoded from the next state so they align with it
        out_valid_d = bus.buf_enable_process;
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
`ifdef IMG_SEQ_TIMEOUT_EN
        error_d     = (state_d == S_ERR);
`endif
    end

    // State, counters and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef IMG_SEQ_TIMEOUT_EN
            tmo_q       <= '0;
            error_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef IMG_SEQ_TIMEOUT_EN
            tmo_q       <= tmo_d;
            error_q     <= error_d;
`endif
        end
    end

endmodule

// File: tb/tb_img_frame_seq.sv
// tb_img_frame_seq: directed + randomized bench for img_frame_seq with a
// frame-level reference model (phase plus linear pixel index).
module tb_img_frame_seq;

    localparam int unsigned W   = 4;
    localparam int unsigned D   = 3;
    localparam int unsigned N   = W * D;
    localparam int unsigned TMO = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    img_frame_seq_if bus ();

    img_frame_seq #(
        .WIDTH   (W),
        .DEPTH   (D),
        .TIMEOUT (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef enum int {P_IDLE, P_LOAD, P_TURN, P_PROC, P_DRAIN, P_DONE, P_ERR} phase_e;

    phase_e ph;
    int     k;
    int     tw;
    logic   prev_ep;

    int n_total;
    int n_pass;

    int f_be, f_ep, f_ov, f_done_at, f_ov_first, f_ov_last, f_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One clock cycle: drive inputs, check against the model, advance model
    task automatic cyc(input logic sv, input logic sr, input logic st, input logic bf);
        logic exp_be;
        logic exp_ep;
        @(negedge clk);
        bus.start      = st;
        bus.src_valid  = sv;
        bus.sink_ready = sr;
        bus.buf_finish = bf;
        #1;
        exp_be = (ph == P_LOAD) && sv;
        exp_ep = (ph == P_PROC) && sr;
        chk("src_ready",  32'(bus.src_ready),          32'(ph == P_LOAD));
        chk("buf_enable", 32'(bus.buf_enable),         32'(exp_be));
        chk("enable_proc", 32'(bus.buf_enable_process), 32'(exp_ep));
        chk("out_valid",  32'(bus.out_valid),          32'(prev_ep));
        chk("pix_x",      32'(bus.pix_x),              32'(k % W));
        chk("pix_y",      32'(bus.pix_y),              32'(k / W));
        chk("busy",       32'(bus.busy),               32'(ph != P_IDLE));
        chk("done",       32'(bus.done),               32'(ph == P_DONE));
        chk("error",      32'(bus.error),              32'(ph == P_ERR));
        chk("exclusive",  32'(bus.buf_enable & bus.buf_enable_process), 32'(0));
        if (bus.buf_enable === 1'b1) f_be++;
        if (bus.buf_enable_process === 1'b1) f_ep++;
        if (bus.out_valid === 1'b1) begin
            f_ov++;
            if (f_ov_first < 0) f_ov_first = f_cyc;
            f_ov_last = f_cyc;
        end
        if (bus.done === 1'b1) f_done_at = f_cyc;
        f_cyc++;
        prev_ep = exp_ep;
        case (ph)
            P_IDLE: if (st) ph = P_LOAD;
            P_LOAD: if (sv) begin
                k++;
                if (k == int'(N)) begin k = 0; ph = P_TURN; end
            end
            P_TURN: ph = P_PROC;
            P_PROC: if (sr) begin
                k++;
                if (k == int'(N)) begin k = 0; tw = 0; ph = P_DRAIN; end
            end
            P_DRAIN: begin
`ifdef IMG_SEQ_TIMEOUT_EN
                if (bf) ph = P_DONE;
                else begin
                    tw++;
                    if (tw == int'(TMO)) ph = P_ERR;
                end
`else
                ph = P_DONE;
`endif
            end
            P_DONE: ph = P_IDLE;
            P_ERR:  if (st) ph = P_LOAD;
            default: ph = P_IDLE;
        endcase
    endtask

    // Start pulse at frame cycle 0, then run until IDLE/ERR under a pattern
    task automatic run_frame(input int mode);
        int   stall;
        logic sv, sr, st, bf;
        bit   fin;
        f_be = 0; f_ep = 0; f_ov = 0; f_cyc = 0;
        f_done_at = -1; f_ov_first = -1; f_ov_last = -1;
        stall = 0;
        fin = 1'b0;
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 2000 && !fin; c++) begin
            sv = 1'b1; sr = 1'b1; st = 1'b0; bf = 1'b1;
            case (mode)
                1: sv = (c % 2 == 0);
                2: if (ph == P_PROC && k == int'(W + 2) && stall < 5) begin
                    sr = 1'b0;
                    stall++;
                end
                3: begin
                    sv = 1'($urandom_range(0, 1));
                    sr = 1'($urandom_range(0, 1));
                    st = ($urandom_range(0, 3) == 0) && (ph == P_LOAD || ph == P_PROC);
                    bf = 1'($urandom_range(0, 1));
                end
                4: bf = 1'b0;
                default: ;
            endcase
            cyc(sv, sr, st, bf);
            fin = (ph == P_IDLE) || (ph == P_ERR);
        end
        chk("frame_budget", 32'(fin), 32'(1));
        chk("be_count", 32'(f_be), 32'(N));
        chk("ep_count", 32'(f_ep), 32'(N));
        chk("ov_count", 32'(f_ov), 32'(N));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        n_total = 0; n_pass = 0;
        ph = P_IDLE; k = 0; tw = 0; prev_ep = 1'b0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.src_valid = 1'b0; bus.sink_ready = 1'b0; bus.buf_finish = 1'b0;

        // Reset state
        #12;
        chk("rst_src_ready", 32'(bus.src_ready), 32'(0));
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_busy",      32'(bus.busy),      32'(0));
        chk("rst_done",      32'(bus.done),      32'(0));
        chk("rst_error",     32'(bus.error),     32'(0));
        chk("rst_pix",       32'({bus.pix_y, bus.pix_x}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // No-stall frame
        run_frame(0);
        chk("done_cycle",   32'(f_done_at), 32'(27));
        chk("ov_first",     32'(f_ov_first), 32'(15));
        chk("ov_span",      32'(f_ov_last - f_ov_first + 1), 32'(N));

        // src_valid toggling
        run_frame(1);
        chk("done_cycle_toggle", 32'(f_done_at), 32'(38));

        // Sink stall of 5 cycles at pixel (2,1)
        run_frame(2);
        chk("ov_span_stall",    32'(f_ov_last - f_ov_first + 1), 32'(N + 5));
        chk("done_cycle_stall", 32'(f_done_at), 32'(32));

        // Random handshakes with stray start pulses
        for (int i = 0; i < 4; i++) run_frame(3);

        // Reset mid-LOAD at pixel (1,2)
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 100 && !(ph == P_LOAD && k == int'(2 * W + 1)); c++)
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("reset_point", 32'(k), 32'(2 * W + 1));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_src_ready", 32'(bus.src_ready),  32'(0));
        chk("mid_rst_buf_en",    32'(bus.buf_enable), 32'(0));
        chk("mid_rst_enp",       32'(bus.buf_enable_process), 32'(0));
        chk("mid_rst_out_valid", 32'(bus.out_valid),  32'(0));
        chk("mid_rst_pix",       32'({bus.pix_y, bus.pix_x}), 32'(0));
        chk("mid_rst_busy",      32'(bus.busy),       32'(0));
        chk("mid_rst_done",      32'(bus.done),       32'(0));
        chk("mid_rst_error",     32'(bus.error),      32'(0));
        ph = P_IDLE; k = 0; prev_ep = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(0);
        chk("done_cycle_after_rst", 32'(f_done_at), 32'(27));

`ifdef IMG_SEQ_TIMEOUT_EN
        // buf_finish never arrives: timeout into ERR, then restart clears it
        run_frame(4);
        chk("timeout_no_done", 32'(f_done_at), 32'(-1));
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        run_frame(0);
        chk("done_after_err", 32'(f_done_at), 32'(27));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
